// File: rtl/ram_wt.sv
// ram_wt: eight-word write-stage register file plus one memory-mapped output port with valid/ack handshake.
// Define RAM_WT_IO_OVR_EN to add the sticky IO64_OVR overrun flag.
module ram_wt #(
   parameter logic [7:0] IO_ADDR = 8'h40
) (
   input  logic        CLK_WT,
   input  logic        RESET_N,
   input  logic        RAM_WEN,
   input  logic [7:0]  RAM_AD_IN,
   input  logic [15:0] RAM_IN,
   input  logic        IO64_ACK,
   output logic [15:0] RAM_0,
   output logic [15:0] RAM_1,
   output logic [15:0] RAM_2,
   output logic [15:0] RAM_3,
   output logic [15:0] RAM_4,
   output logic [15:0] RAM_5,
   output logic [15:0] RAM_6,
   output logic [15:0] RAM_7,
   output logic [15:0] IO64_OUT,
`ifdef RAM_WT_IO_OVR_EN
   output logic        IO64_OVR,
`endif
   output logic        IO64_VALID
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t      r_state;
   logic [15:0] r_io_out;
   logic        r_io_valid;
   logic        w_ram_wr;
   logic        w_io_wr;

   // Only addresses 0..7 reach the word file; the upper bits must be zero so nothing aliases.
   assign w_ram_wr = RAM_WEN && (RAM_AD_IN[7:3] == 5'd0);
   assign w_io_wr  = RAM_WEN && (RAM_AD_IN == IO_ADDR);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_word
         logic [15:0] r_word;
         always_ff @(posedge CLK_WT or negedge RESET_N) begin
            if (!RESET_N) begin
               r_word <= 16'h0000;
            end else if (w_ram_wr && (RAM_AD_IN[2:0] == 3'(gi))) begin
               r_word <= RAM_IN;
            end
         end
      end
   endgenerate

   assign RAM_0 = g_word[0].r_word;
   assign RAM_1 = g_word[1].r_word;
   assign RAM_2 = g_word[2].r_word;
   assign RAM_3 = g_word[3].r_word;
   assign RAM_4 = g_word[4].r_word;
   assign RAM_5 = g_word[5].r_word;
   assign RAM_6 = g_word[6].r_word;
   assign RAM_7 = g_word[7].r_word;

`ifdef RAM_WT_IO_OVR_EN
   logic r_io_ovr;
`endif

   always_ff @(posedge CLK_WT or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_io_out   <= 16'h0000;
         r_io_valid <= 1'b0;
`ifdef RAM_WT_IO_OVR_EN
         r_io_ovr   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_io_wr) begin
                  r_state    <= S_PEND;
                  r_io_out   <= RAM_IN;
                  r_io_valid <= 1'b1;
               end
            end
            S_PEND: begin
               if (w_io_wr) begin
                  // A write in the same cycle as ack replaces a retired word, so it is not an overrun.
                  r_io_out <= RAM_IN;
`ifdef RAM_WT_IO_OVR_EN
                  if (!IO64_ACK) begin
                     r_io_ovr <= 1'b1;
                  end
`endif
               end else if (IO64_ACK) begin
                  r_state    <= S_IDLE;
                  r_io_valid <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_io_valid <= 1'b0;
            end
         endcase
      end
   end

   assign IO64_OUT   = r_io_out;
   assign IO64_VALID = r_io_valid;
`ifdef RAM_WT_IO_OVR_EN
   assign IO64_OVR   = r_io_ovr;
`endif

endmodule

// File: tb/tb_ram_wt.sv
// Self-checking bench for ram_wt: directed scenarios followed by randomized traffic against a behavioural model.
module tb_ram_wt;

   logic        CLK_WT;
   logic        RESET_N;
   logic        RAM_WEN;
   logic [7:0]  RAM_AD_IN;
   logic [15:0] RAM_IN;
   logic        IO64_ACK;
   logic [15:0] RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7;
   logic [15:0] IO64_OUT;
   logic        IO64_VALID;
   logic        w_ovr;

   ram_wt #(.IO_ADDR(8'h40)) dut (
      .CLK_WT    (CLK_WT),
      .RESET_N   (RESET_N),
      .RAM_WEN   (RAM_WEN),
      .RAM_AD_IN (RAM_AD_IN),
      .RAM_IN    (RAM_IN),
      .IO64_ACK  (IO64_ACK),
      .RAM_0     (RAM_0),
      .RAM_1     (RAM_1),
      .RAM_2     (RAM_2),
      .RAM_3     (RAM_3),
      .RAM_4     (RAM_4),
      .RAM_5     (RAM_5),
      .RAM_6     (RAM_6),
      .RAM_7     (RAM_7),
      .IO64_OUT  (IO64_OUT),
`ifdef RAM_WT_IO_OVR_EN
      .IO64_OVR  (w_ovr),
`endif
      .IO64_VALID(IO64_VALID)
   );

`ifndef RAM_WT_IO_OVR_EN
   assign w_ovr = 1'b0;
`endif

   logic [15:0] w_ram [8];
   assign w_ram[0] = RAM_0;
   assign w_ram[1] = RAM_1;
   assign w_ram[2] = RAM_2;
   assign w_ram[3] = RAM_3;
   assign w_ram[4] = RAM_4;
   assign w_ram[5] = RAM_5;
   assign w_ram[6] = RAM_6;
   assign w_ram[7] = RAM_7;

   initial begin
      CLK_WT = 1'b0;
      forever #5 CLK_WT = ~CLK_WT;
   end

   // Behavioural reference state
   logic [15:0] m_ram [8];
   logic [15:0] m_out;
   logic        m_valid;
   logic        m_ovr;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n_cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_ram[i] = 16'h0000;
      m_out   = 16'h0000;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) chk($sformatf("%s.ram%0d", tag, i), {16'h0, w_ram[i]}, {16'h0, m_ram[i]});
      chk({tag, ".out"},   {16'h0, IO64_OUT}, {16'h0, m_out});
      chk({tag, ".valid"}, {31'h0, IO64_VALID}, {31'h0, m_valid});
`ifdef RAM_WT_IO_OVR_EN
      chk({tag, ".ovr"},   {31'h0, w_ovr}, {31'h0, m_ovr});
`endif
   endtask

   // One clock transaction: drive, clock, update model from the rules, then check 1 time unit after the edge.
   task automatic step(input string tag, input logic wen, input logic [7:0] ad,
                       input logic [15:0] din, input logic ack);
      RAM_WEN   = wen;
      RAM_AD_IN = ad;
      RAM_IN    = din;
      IO64_ACK  = ack;
      @(posedge CLK_WT);
      n_cyc++;
      if (RESET_N) begin
         if (wen && ad < 8) m_ram[ad[2:0]] = din;
         if (wen && ad == 8'h40) begin
            if (m_valid && !ack) m_ovr = 1'b1;
            m_out   = din;
            m_valid = 1'b1;
         end else if (ack) begin
            m_valid = 1'b0;
         end
      end
      #1;
      $display("[TB] %s cyc=%0d wen=%0b ad=%0d din=%h ack=%0b -> out=%h valid=%0b",
               tag, n_cyc, wen, ad, din, ack, IO64_OUT, IO64_VALID);
      check_all(tag);
      RAM_WEN  = 1'b0;
      IO64_ACK = 1'b0;
   endtask

   logic [7:0]  r_ad;
   logic [15:0] r_din;

   initial begin
      RESET_N   = 1'b0;
      RAM_WEN   = 1'b0;
      RAM_AD_IN = 8'h00;
      RAM_IN    = 16'h0000;
      IO64_ACK  = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK_WT);
      #3;
      check_all("reset");
      RESET_N = 1'b1;

      // Plain word write
      step("wr3", 1'b1, 8'd3, 16'hBEEF, 1'b0);
      // Disabled write and out-of-range addresses
      step("wen0", 1'b0, 8'd2, 16'h1234, 1'b0);
      step("ad8", 1'b1, 8'd8, 16'h1234, 1'b0);
      step("ad65", 1'b1, 8'd65, 16'h1234, 1'b0);
      step("ad72", 1'b1, 8'd72, 16'h5555, 1'b0);
      step("ad255", 1'b1, 8'd255, 16'h6666, 1'b0);
      step("ackidle", 1'b0, 8'd0, 16'h0000, 1'b1);

      // IO write, hold without ack, then ack
      step("io", 1'b1, 8'h40, 16'h00A5, 1'b0);
      for (int i = 0; i < 5; i++) step("hold", 1'b0, 8'h40, 16'hFFFF, 1'b0);
      step("ack", 1'b0, 8'd0, 16'h0000, 1'b1);
      step("idle", 1'b0, 8'd0, 16'h0000, 1'b0);

      // Write with ack in PEND is not an overrun
      step("io2", 1'b1, 8'h40, 16'h0042, 1'b0);
      step("wrack", 1'b1, 8'h40, 16'h0001, 1'b1);
      // Overrun
      step("ovr", 1'b1, 8'h40, 16'h0002, 1'b0);
      step("ovrack", 1'b0, 8'd0, 16'h0000, 1'b1);
      step("ovrstk", 1'b0, 8'd0, 16'h0000, 1'b0);

      // Asynchronous reset mid-PEND
      step("io3", 1'b1, 8'h40, 16'h7777, 1'b0);
      #2;
      RESET_N = 1'b0;
      model_reset();
      #1;
      check_all("arst");
      step("inrst", 1'b1, 8'd1, 16'hAAAA, 1'b0);
      #2;
      RESET_N = 1'b1;
      step("postrst", 1'b0, 8'd0, 16'h0000, 1'b1);

      // Randomized traffic biased toward interesting addresses
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 5))
            0, 1:    r_ad = 8'($urandom_range(0, 7));
            2, 3:    r_ad = 8'h40;
            4:       r_ad = 8'h41;
            default: r_ad = 8'($urandom_range(0, 255));
         endcase
         r_din = 16'($urandom);
         step("rnd", 1'($urandom_range(0, 1)), r_ad, r_din, ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
